phys_free_list: RTL and testbench
=================================

Name: phys_free_list

Overview:
- Circular FIFO of free physical register tags. It sits directly upstream of the RAT: rename pops a tag from it for each destination write, and that tag becomes the RAT's new mapping.
- Commit frees the previous mapping, which is pushed back here.
- A committed-head checkpoint lets a pipeline flush roll back all speculative allocations in a single cycle.

Parameters:
- NUM_ARCH_REGS, rob_pkg::NUM_ARCH_REGS (32): architectural register count.
- NUM_PHYS_REGS, rob_pkg::NUM_PHYS_REGS (64): physical register count and FIFO depth; must be a power of 2 and greater than NUM_ARCH_REGS.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid_in  in  1  rename consumes the head tag this cycle.
- alloc_ready_out  out  1  list is non-empty; the head tag is valid.
- alloc_preg_out  out  $clog2(NUM_PHYS_REGS)  head tag, combinational read of the registered head.
- commit_valid_in  in  1  the oldest allocating instruction commits; advances the committed head.
- release_valid_in  in  1  push a freed tag (the old mapping of a committed instruction).
- release_preg_in  in  $clog2(NUM_PHYS_REGS)  tag to push.
- flush_in  in  1  mispredict or exception: restore the speculative head to the committed head.
- free_count_out  out  $clog2(NUM_PHYS_REGS)+1  number of free tags at the speculative head.
- err_out  out  1  sticky protocol error.

Behaviour:
- Storage: NUM_PHYS_REGS entries; spec_head, commit_head and tail pointers, each with an extra wrap bit.
- Empty: spec_head == tail. Full: tail - commit_head == NUM_PHYS_REGS.
- Reset (async, immediate):
  - entries 0..(NUM_PHYS_REGS-NUM_ARCH_REGS-1) hold tags NUM_ARCH_REGS..NUM_PHYS_REGS-1 in order;
  - spec_head = commit_head = 0; tail = NUM_PHYS_REGS-NUM_ARCH_REGS;
  - free_count_out = NUM_PHYS_REGS-NUM_ARCH_REGS; alloc_ready_out = 1; alloc_preg_out = NUM_ARCH_REGS; err_out = 0.
- Reset mid-operation discards all state.
- Allocate: if alloc_valid_in && alloc_ready_out, spec_head advances at posedge. A new head is visible the next cycle (0-cycle read, 1-cycle update).
  - alloc_valid_in while empty is ignored and sets err_out.
- Release: if release_valid_in, the entry at tail is written with release_preg_in and tail advances.
  - Release while full is dropped and sets err_out.
  - No same-cycle bypass: a release into an empty list raises alloc_ready_out only in the next cycle.
- Commit: commit_head advances by 1.
  - commit_valid_in when commit_head == spec_head (nothing allocated speculatively) is ignored and sets err_out.
- Flush: spec_head <= commit_head (taking that cycle's commit into account).
  - flush_in has priority over alloc_valid_in, which is ignored in a flush cycle.
  - Release is still honoured in a flush cycle.
  - free_count_out the cycle after a flush = tail - commit_head (updated values).
- Simultaneous alloc + release on a non-empty list: both take effect; free_count_out is unchanged.
- free_count_out = tail - spec_head, registered pointers only.
- Wrap-around: pointer index bits wrap modulo NUM_PHYS_REGS; the wrap bit toggles.
- err_out is cleared only by rst.

Optional Feature:
- FREE_LIST_DUP_CHECK_EN defined:
  - a NUM_PHYS_REGS-bit free bitmap is maintained, with the same reset image as the FIFO;
  - allocate clears the head tag's bit, flush re-sets the bits of all rolled-back tags, release sets the bit;
  - releasing a tag whose bit is already set, or any tag < NUM_ARCH_REGS while its bit is set, drops the push and sets err_out.
- Not defined: no bitmap; duplicate releases are pushed unchecked.

Test Plan:
- Reset with NUM_ARCH=32, NUM_PHYS=64 -> free_count_out=32, alloc_preg_out=32, alloc_ready_out=1, err_out=0.
- 32 consecutive allocs -> tags 32..63 in order, then alloc_ready_out=0, free_count_out=0. A 33rd alloc sets err_out=1 and leaves spec_head unchanged.
- Alloc 5, commit 2, flush -> next cycle alloc_preg_out=34, free_count_out=30.
- Same cycle: release tag 7, commit 1, flush, alloc_valid_in=1 -> alloc ignored; spec_head = commit_head; tail+1.
- Drain list, release tag 3 -> alloc_ready_out=0 in that cycle, 1 next cycle with alloc_preg_out=3.
- Wrap: cycle 100 alloc/commit/release pairs -> pointers wrap; FIFO order preserved; free_count_out stable at 32.
- With FREE_LIST_DUP_CHECK_EN: release tag 40 while it is still free -> dropped, err_out=1.

Source files
------------

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags with a committed-head checkpoint for single-cycle flush rollback.
// Define FREE_LIST_DUP_CHECK_EN to add a free bitmap that rejects duplicate releases.
module phys_free_list #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int NUM_PHYS_REGS = 64,
  localparam int PW = $clog2(NUM_PHYS_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_valid_in,
  output logic          alloc_ready_out,
  output logic [PW-1:0] alloc_preg_out,
  input  logic          commit_valid_in,
  input  logic          release_valid_in,
  input  logic [PW-1:0] release_preg_in,
  input  logic          flush_in,
  output logic [PW:0]   free_count_out,
  output logic          err_out
);

  localparam logic [PW:0] DEPTH     = (PW+1)'(NUM_PHYS_REGS);
  localparam logic [PW:0] INIT_TAIL = (PW+1)'(NUM_PHYS_REGS - NUM_ARCH_REGS);

  logic [PW-1:0] mem [NUM_PHYS_REGS];
  logic [PW:0]   spec_head, commit_head, tail;
  logic [PW:0]   spec_head_nxt, commit_head_nxt, tail_nxt;
  logic          empty, full, dup;
  logic          alloc_ok, commit_ok, release_ok, err_set;

  assign alloc_preg_out  = mem[spec_head[PW-1:0]];
  assign alloc_ready_out = !empty;
  assign free_count_out  = tail - spec_head;

  always_comb begin
    empty      = (spec_head == tail);
    full       = ((tail - commit_head) == DEPTH);
    alloc_ok   = alloc_valid_in && !flush_in && !empty;
    commit_ok  = commit_valid_in && (commit_head != spec_head);
    release_ok = release_valid_in && !full && !dup;
    err_set    = (alloc_valid_in && !flush_in && empty)
               || (commit_valid_in && (commit_head == spec_head))
               || (release_valid_in && (full || dup));
    commit_head_nxt = commit_head + (PW+1)'(commit_ok);
    spec_head_nxt   = flush_in ? commit_head_nxt : spec_head + (PW+1)'(alloc_ok);
    tail_nxt        = tail + (PW+1)'(release_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= INIT_TAIL;
      err_out     <= 1'b0;
    end else begin
      spec_head   <= spec_head_nxt;
      commit_head <= commit_head_nxt;
      tail        <= tail_nxt;
      if (err_set) err_out <= 1'b1;
    end
  end

  // Tags above the architectural range start out free, in ascending order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++)
        mem[i] <= (i < NUM_PHYS_REGS - NUM_ARCH_REGS) ? PW'(NUM_ARCH_REGS + i) : '0;
    end else if (release_ok) begin
      mem[tail[PW-1:0]] <= release_preg_in;
    end
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [NUM_PHYS_REGS-1:0] free_map, free_map_nxt;
  logic [PW:0]              rb_cnt;
  logic [PW-1:0]            rb_off;

  assign dup = free_map[release_preg_in];

  // Rolled-back entries sit between the new committed head and the old speculative head.
  always_comb begin
    free_map_nxt = free_map;
    rb_cnt       = spec_head - commit_head_nxt;
    rb_off       = '0;
    if (flush_in) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        rb_off = PW'(i) - commit_head_nxt[PW-1:0];
        if ({1'b0, rb_off} < rb_cnt) free_map_nxt[mem[i]] = 1'b1;
      end
    end
    if (alloc_ok)   free_map_nxt[alloc_preg_out]  = 1'b0;
    if (release_ok) free_map_nxt[release_preg_in] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++)
        free_map[i] <= (i >= NUM_ARCH_REGS);
    end else begin
      free_map <= free_map_nxt;
    end
  end
`else
  assign dup = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Directed self-checking bench for phys_free_list (32 arch / 64 phys tags).
module tb_phys_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid_in;
  logic       alloc_ready_out;
  logic [5:0] alloc_preg_out;
  logic       commit_valid_in;
  logic       release_valid_in;
  logic [5:0] release_preg_in;
  logic       flush_in;
  logic [6:0] free_count_out;
  logic       err_out;

  int n_pass = 0;
  int n_chk  = 0;
  int q[$];
  int exp_tag;
  int rel;

  phys_free_list #(.NUM_ARCH_REGS(32), .NUM_PHYS_REGS(64)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid_in(alloc_valid_in), .alloc_ready_out(alloc_ready_out),
    .alloc_preg_out(alloc_preg_out), .commit_valid_in(commit_valid_in),
    .release_valid_in(release_valid_in), .release_preg_in(release_preg_in),
    .flush_in(flush_in), .free_count_out(free_count_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic idle();
    alloc_valid_in   = 1'b0;
    commit_valid_in  = 1'b0;
    release_valid_in = 1'b0;
    release_preg_in  = '0;
    flush_in         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Assert reset between edges and leave it released 1ns after the next edge.
  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    check("rst_free_count", free_count_out, 32);
    check("rst_preg", alloc_preg_out, 32);
    check("rst_ready", alloc_ready_out, 1);
    check("rst_err", err_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Drain all 32 free tags in order
    for (int i = 0; i < 32; i++) begin
      check("alloc_seq", alloc_preg_out, 32 + i);
      alloc_valid_in = 1'b1;
      tick();
    end
    check("drained_ready", alloc_ready_out, 0);
    check("drained_count", free_count_out, 0);
    check("drained_err", err_out, 0);
    alloc_valid_in = 1'b1;
    tick();
    check("alloc_empty_err", err_out, 1);
    check("alloc_empty_count", free_count_out, 0);

    // Mid-operation reset takes effect immediately
    rst = 1'b1;
    #1;
    check("midrst_err", err_out, 0);
    check("midrst_count", free_count_out, 32);
    check("midrst_preg", alloc_preg_out, 32);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Alloc 5, commit 2 (second commit shares the flush cycle), flush
    for (int i = 0; i < 5; i++) begin
      alloc_valid_in = 1'b1;
      tick();
    end
    commit_valid_in = 1'b1;
    tick();
    commit_valid_in = 1'b1;
    flush_in        = 1'b1;
    tick();
    check("flush_preg", alloc_preg_out, 34);
    check("flush_count", free_count_out, 30);
    check("flush_err", err_out, 0);

    // Two more allocs, then release+commit+flush+alloc in one cycle
    alloc_valid_in = 1'b1;
    tick();
    alloc_valid_in = 1'b1;
    tick();
    check("pre_combo_preg", alloc_preg_out, 36);
    check("pre_combo_count", free_count_out, 28);
    release_valid_in = 1'b1;
    release_preg_in  = 6'd7;
    commit_valid_in  = 1'b1;
    flush_in         = 1'b1;
    alloc_valid_in   = 1'b1;
    tick();
    check("combo_preg", alloc_preg_out, 35);
    check("combo_count", free_count_out, 30);
    check("combo_err", err_out, 0);

    // Commit with nothing speculatively allocated is an error
    do_reset();
    commit_valid_in = 1'b1;
    tick();
    check("commit_idle_err", err_out, 1);
    check("commit_idle_count", free_count_out, 32);

    // Drain, then release tag 3 into the empty list: no same-cycle bypass
    do_reset();
    for (int i = 0; i < 32; i++) begin
      alloc_valid_in = 1'b1;
      tick();
    end
    release_valid_in = 1'b1;
    release_preg_in  = 6'd3;
    #1;
    check("rel_empty_ready_now", alloc_ready_out, 0);
    tick();
    check("rel_empty_ready_next", alloc_ready_out, 1);
    check("rel_empty_preg", alloc_preg_out, 3);
    check("rel_empty_count", free_count_out, 1);
    check("rel_empty_err", err_out, 0);

    // Fill to 64 entries, then one more release is dropped
    do_reset();
    for (int i = 0; i < 32; i++) begin
      release_valid_in = 1'b1;
      release_preg_in  = 6'(i);
      tick();
    end
    check("full_count", free_count_out, 64);
    check("full_err_before", err_out, 0);
    release_valid_in = 1'b1;
    release_preg_in  = 6'd9;
    tick();
    check("full_drop_count", free_count_out, 64);
    check("full_drop_err", err_out, 1);

    // Wrap: 100 cycles of alloc+release with commit trailing by one
    do_reset();
    for (int t = 32; t < 64; t++) q.push_back(t);
    for (int k = 0; k < 100; k++) begin
      exp_tag = q.pop_front();
      check("wrap_preg", alloc_preg_out, exp_tag);
      check("wrap_count", free_count_out, 32);
      rel = (k * 7 + 3) % 64;
      q.push_back(rel);
      alloc_valid_in   = 1'b1;
      release_valid_in = 1'b1;
      release_preg_in  = 6'(rel);
      commit_valid_in  = (k > 0);
      tick();
    end
    check("wrap_final_preg", alloc_preg_out, q[0]);
    check("wrap_final_count", free_count_out, 32);
    check("wrap_err", err_out, 0);

    // Releasing a tag that is already free
    do_reset();
    release_valid_in = 1'b1;
    release_preg_in  = 6'd40;
    tick();
`ifdef FREE_LIST_DUP_CHECK_EN
    check("dup_err", err_out, 1);
    check("dup_count", free_count_out, 32);
`else
    check("dup_err", err_out, 0);
    check("dup_count", free_count_out, 33);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
